// File: rtl/rah_pkg.sv
// Shared definitions for the RAH transmit arbiter: arbitration modes, FSM
// state encoding and the app-ID width helper.
package rah_pkg;

   // Arbitration policy selectors for ARB_MODE
   localparam int unsigned ArbRoundRobin = 0;
   localparam int unsigned ArbFixedPrio  = 1;

   // Arbiter FSM states
   localparam logic [0:0] StIdle  = 1'b0;
   localparam logic [0:0] StGrant = 1'b1;

   // App-ID width; a single app still gets a 1-bit ID
   function automatic int unsigned app_id_width(input int unsigned num_apps);
      return (num_apps > 1) ? $clog2(num_apps) : 1;
   endfunction

endpackage

// File: rtl/rah_app_fifo.sv
// Per-application first-word-fall-through buffer with occupancy count and a
// sticky overflow flag for writes attempted while full.
module rah_app_fifo #(
   parameter int unsigned DATA_WIDTH = 48,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          wr_valid_i,
   input  logic [DATA_WIDTH-1:0]         wr_data_i,
   output logic                          wr_ready_o,
   input  logic                          rd_i,
   output logic [DATA_WIDTH-1:0]         rd_data_o,
   output logic [$clog2(FIFO_DEPTH):0]   count_o,
   output logic                          overflow_o
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]       count_q;
   logic                  overflow_q;
   logic                  wr_en, rd_en;

   // Ready uses the pre-read count, so a same-cycle read never frees a slot
   assign wr_ready_o = (count_q != CntW'(FIFO_DEPTH));
   assign wr_en      = wr_valid_i && wr_ready_o;
   assign rd_en      = rd_i && (count_q != '0);
   assign rd_data_o  = mem_q[rd_ptr_q];
   assign count_o    = count_q;
   assign overflow_o = overflow_q;

   // Storage array, no reset needed
   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_data_i;
   end

   // Pointers wrap naturally since the depth is a power of two
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (wr_en && !rd_en)      count_q <= count_q + 1'b1;
         else if (!wr_en && rd_en) count_q <= count_q - 1'b1;
         if (wr_valid_i && !wr_ready_o) overflow_q <= 1'b1;
      end
   end

endmodule

// File: rtl/rah_tx_arbiter.sv
// Multi-application RAH transmit arbiter: per-app FWFT buffers feeding a
// burst-limited round-robin or fixed-priority grant onto one output stream.
module rah_tx_arbiter
   import rah_pkg::*;
#(
   parameter int unsigned NUM_APPS   = 2,
   parameter int unsigned DATA_WIDTH = 48,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned MAX_BURST  = 8,
   parameter int unsigned ARB_MODE   = 0
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic [NUM_APPS-1:0]               in_valid,
   input  logic [NUM_APPS*DATA_WIDTH-1:0]    in_data,
   output logic [NUM_APPS-1:0]               in_ready,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [DATA_WIDTH-1:0]             out_data,
   output logic [app_id_width(NUM_APPS)-1:0] out_app_id,
   output logic                              out_last,
   output logic [NUM_APPS-1:0]               overflow
);

   localparam int unsigned AppIdW = app_id_width(NUM_APPS);
   localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned BeatW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   logic [DATA_WIDTH-1:0] head       [NUM_APPS];
   logic [CntW-1:0]       fifo_count [NUM_APPS];
   logic [NUM_APPS-1:0]   fifo_rd, nonempty, rot;
   logic [2*NUM_APPS-1:0] ne_dbl;

   logic [0:0]            state_q;
   logic [AppIdW-1:0]     grant_q, rr_ptr_q, winner, rr_next;
   logic [BeatW-1:0]      beat_cnt_q;
   logic [CntW-1:0]       gcount;
   logic                  fire;
   int                    sum;

   for (genvar i = 0; i < NUM_APPS; i++) begin : g_app
      rah_app_fifo #(
         .DATA_WIDTH (DATA_WIDTH),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk_i      (clk),
         .rst_ni     (rstn),
         .wr_valid_i (in_valid[i]),
         .wr_data_i  (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
         .wr_ready_o (in_ready[i]),
         .rd_i       (fifo_rd[i]),
         .rd_data_o  (head[i]),
         .count_o    (fifo_count[i]),
         .overflow_o (overflow[i])
      );
      assign nonempty[i] = (fifo_count[i] != '0);
      assign fifo_rd[i]  = fire && (grant_q == AppIdW'(i));
   end

   // Rotating the request vector by rr_ptr turns the wrap search into a priority pick
   assign ne_dbl = {nonempty, nonempty};
   assign rot    = NUM_APPS'(ne_dbl >> rr_ptr_q);

   // Winner selection; descending loops so the lowest candidate is assigned last
   always_comb begin
      winner = '0;
      sum    = 0;
      if (ARB_MODE == ArbFixedPrio) begin
         for (int i = int'(NUM_APPS) - 1; i >= 0; i--) begin
            if (nonempty[i]) winner = AppIdW'(i);
         end
      end else begin
         for (int k = int'(NUM_APPS) - 1; k >= 0; k--) begin
            if (rot[k]) begin
               sum = int'(rr_ptr_q) + k;
               if (sum >= int'(NUM_APPS)) sum = sum - int'(NUM_APPS);
               winner = AppIdW'(sum);
            end
         end
      end
   end

   assign gcount     = fifo_count[grant_q];
   assign out_valid  = (state_q == StGrant) && (gcount != '0);
   assign out_data   = head[grant_q];
   assign out_app_id = grant_q;
   // Last beat of the grant: burst limit reached or the buffer holds only this beat
   assign out_last   = out_valid && ((beat_cnt_q == BeatW'(MAX_BURST - 1)) ||
                                     (gcount == CntW'(1)));
   assign fire       = out_valid && out_ready;
   assign rr_next    = (grant_q == AppIdW'(NUM_APPS - 1)) ? '0 : grant_q + 1'b1;

   // Grant FSM: one bubble cycle in IDLE, then up to MAX_BURST beats in GRANT
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= StIdle;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (|nonempty) begin
                  grant_q    <= winner;
                  beat_cnt_q <= '0;
                  state_q    <= StGrant;
               end
            end
            StGrant: begin
               if (fire) begin
                  if (out_last) begin
                     state_q  <= StIdle;
                     rr_ptr_q <= rr_next;
                  end else begin
                     beat_cnt_q <= beat_cnt_q + 1'b1;
                  end
               end else if (gcount == '0) begin
                  // Drained without a last beat: give up the grant, keep rr_ptr
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_rah_tx_arbiter.sv
// Scoreboard bench for rah_tx_arbiter: a round-robin and a fixed-priority
// instance share the same inputs; expected beats are queued per instance.
module tb_rah_tx_arbiter;

   localparam int NA = 3;
   localparam int DW = 48;

   logic              clk, rstn, out_ready;
   logic [NA-1:0]     in_valid;
   logic [NA*DW-1:0]  in_data;

   logic [NA-1:0] rr_in_ready, rr_overflow, fp_in_ready, fp_overflow;
   logic          rr_out_valid, rr_out_last, fp_out_valid, fp_out_last;
   logic [DW-1:0] rr_out_data, fp_out_data;
   logic [1:0]    rr_out_app_id, fp_out_app_id;

   logic [50:0] q_rr[$];
   logic [50:0] q_fp[$];
   bit          mon_fp_en;
   int          n_checks, n_pass;

   rah_tx_arbiter #(
      .NUM_APPS(NA), .DATA_WIDTH(DW), .FIFO_DEPTH(16), .MAX_BURST(4), .ARB_MODE(0)
   ) dut_rr (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rr_in_ready), .out_valid(rr_out_valid), .out_ready(out_ready),
      .out_data(rr_out_data), .out_app_id(rr_out_app_id), .out_last(rr_out_last),
      .overflow(rr_overflow)
   );

   rah_tx_arbiter #(
      .NUM_APPS(NA), .DATA_WIDTH(DW), .FIFO_DEPTH(16), .MAX_BURST(4), .ARB_MODE(1)
   ) dut_fp (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
      .in_ready(fp_in_ready), .out_valid(fp_out_valid), .out_ready(out_ready),
      .out_data(fp_out_data), .out_app_id(fp_out_app_id), .out_last(fp_out_last),
      .overflow(fp_overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic logic [47:0] mk(input int salt, input int app, input int seq);
      return {salt[7:0], app[7:0], seq[31:0]};
   endfunction

   // Queue n expected beats of one app; the final one carries last
   task automatic burst(input bit fp, input int salt, input int app, input int first,
                        input int n);
      logic [50:0] e;
      for (int k = 0; k < n; k++) begin
         e = {(k == n - 1), app[1:0], mk(salt, app, first + k)};
         if (fp) q_fp.push_back(e);
         else    q_rr.push_back(e);
      end
   endtask

   // Write n0/n1/n2 beats into apps 0/1/2 in parallel, one per cycle each
   task automatic load(input int salt, input int n0, input int n1, input int n2);
      int n[3];
      int mx;
      n  = '{n0, n1, n2};
      mx = n0;
      if (n1 > mx) mx = n1;
      if (n2 > mx) mx = n2;
      for (int c = 0; c < mx; c++) begin
         in_valid = '0;
         for (int a = 0; a < NA; a++) begin
            if (c < n[a]) begin
               in_valid[a]          = 1'b1;
               in_data[a*DW +: DW]  = mk(salt, a, c);
            end
         end
         @(posedge clk); #1;
      end
      in_valid = '0;
   endtask

   task automatic do_reset();
      out_ready = 1'b0;
      in_valid  = '0;
      rstn      = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      @(posedge clk); #1;
      q_rr.delete();
      q_fp.delete();
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 300; i++) begin
         if (q_rr.size() == 0 && q_fp.size() == 0) break;
         @(posedge clk); #1;
      end
      chk({tag, "_rr_left"}, q_rr.size(), 0);
      chk({tag, "_fp_left"}, q_fp.size(), 0);
      repeat (6) @(posedge clk);
      #1;
   endtask

   // Handshake monitors: every accepted beat must match the queue head
   always @(negedge clk) begin
      logic [50:0] e;
      if (rstn && rr_out_valid && out_ready) begin
         e = (q_rr.size() != 0) ? q_rr.pop_front() : '1;
         chk("rr_beat", {rr_out_last, rr_out_app_id, rr_out_data}, e);
      end
   end

   always @(negedge clk) begin
      logic [50:0] e;
      if (rstn && mon_fp_en && fp_out_valid && out_ready) begin
         e = (q_fp.size() != 0) ? q_fp.pop_front() : '1;
         chk("fp_beat", {fp_out_last, fp_out_app_id, fp_out_data}, e);
      end
   end

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      mon_fp_en = 1'b0;
      rstn      = 1'b0;
      out_ready = 1'b0;
      in_valid  = '0;
      in_data   = '0;
      #3;
      chk("rst_out_valid", rr_out_valid, 0);
      chk("rst_out_last", rr_out_last, 0);
      chk("rst_app_id", rr_out_app_id, 0);
      chk("rst_in_ready", rr_in_ready, 3'b111);
      chk("rst_overflow", rr_overflow, 3'b000);

      // Short bursts from two apps: A0..A2 then B0..B1
      do_reset();
      load(1, 3, 2, 0);
      burst(0, 1, 0, 0, 3);
      burst(0, 1, 1, 0, 2);
      out_ready = 1'b1;
      drain("basic");

      // Burst limit with alternation, plus a 5-cycle stall mid-burst
      do_reset();
      load(2, 10, 10, 0);
      burst(0, 2, 0, 0, 4);
      burst(0, 2, 1, 0, 4);
      burst(0, 2, 0, 4, 4);
      burst(0, 2, 1, 4, 4);
      burst(0, 2, 0, 8, 2);
      burst(0, 2, 1, 8, 2);
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", rr_out_valid, 1);
         chk("hold_data", rr_out_data, mk(2, 0, 2));
         chk("hold_app_id", rr_out_app_id, 0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      drain("burst");

      // Round-robin versus fixed priority on the same traffic
      do_reset();
      mon_fp_en = 1'b1;
      load(3, 6, 2, 2);
      burst(0, 3, 0, 0, 4);
      burst(0, 3, 1, 0, 2);
      burst(0, 3, 2, 0, 2);
      burst(0, 3, 0, 4, 2);
      burst(1, 3, 0, 0, 4);
      burst(1, 3, 0, 4, 2);
      burst(1, 3, 1, 0, 2);
      burst(1, 3, 2, 0, 2);
      out_ready = 1'b1;
      drain("prio");
      mon_fp_en = 1'b0;

      // Fill app1, then a 17th write must be dropped and flagged
      do_reset();
      load(4, 0, 16, 0);
      chk("full_in_ready", rr_in_ready, 3'b101);
      in_valid[1]        = 1'b1;
      in_data[1*DW +: DW] = mk(4, 1, 99);
      @(posedge clk); #1;
      in_valid = '0;
      chk("ovf_flag", rr_overflow, 3'b010);
      chk("ovf_in_ready", rr_in_ready, 3'b101);
      for (int b = 0; b < 4; b++) burst(0, 4, 1, 4 * b, 4);
      out_ready = 1'b1;
      drain("ovf");
      chk("ovf_sticky", rr_overflow, 3'b010);

      // Reset in the middle of a burst
      do_reset();
      load(5, 6, 0, 0);
      burst(0, 5, 0, 0, 4);
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b0;
      #1;
      chk("midrst_out_valid", rr_out_valid, 0);
      chk("midrst_in_ready", rr_in_ready, 3'b111);
      chk("midrst_overflow", rr_overflow, 3'b000);
      q_rr.delete();
      @(posedge clk);
      #1 rstn = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_quiet", rr_out_valid, 0);
      burst(0, 6, 2, 0, 2);
      load(6, 0, 0, 2);
      drain("midrst");
      chk("end_idle", rr_out_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
